// File: rtl/i_delay_obuf.sv
// Programmable input-delay element with inverting output buffer.
// A 6-bit tap selects how far down a shift line the registered output is taken.
module i_delay_obuf #(
  parameter int unsigned DELAY     = 63,
  parameter int unsigned FIXED_DLY = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_i,
  input  logic       dly_incdec,
  input  logic       dly_ld,
  input  logic       dly_adj,
  output logic       data_o,
  output logic [5:0] dly_tap_val
);

  localparam int unsigned LEN = FIXED_DLY + 64;
  localparam int unsigned IW  = $clog2(LEN);

  logic [5:0]     tap;
  logic [5:0]     tap_nxt;
  logic           adj_q;
  logic           adj_evt;
  logic [LEN-1:0] line;
  logic [IW-1:0]  sel;
  logic           data_q;

  assign adj_evt = ~dly_adj & adj_q;

  // Load has priority over a step; steps saturate at both ends.
  always_comb begin
    tap_nxt = tap;
    if (!dly_ld) begin
      tap_nxt = 6'(DELAY);
    end else if (adj_evt) begin
      if (dly_incdec) begin
        if (tap != 6'd63) tap_nxt = tap + 6'd1;
      end else begin
        if (tap != 6'd0) tap_nxt = tap - 6'd1;
      end
    end
  end

  // Smaller tap reaches further down the line, i.e. longer latency.
  assign sel = IW'(FIXED_DLY - 1) + IW'(6'd63 - tap);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tap    <= 6'(DELAY);
      adj_q  <= 1'b1;
      line   <= '0;
      data_q <= 1'b0;
    end else begin
      tap    <= tap_nxt;
      adj_q  <= dly_adj;
      line   <= {line[LEN-2:0], ~data_i};
      data_q <= line[sel];
    end
  end

  assign data_o      = data_q;
  assign dly_tap_val = tap;

endmodule

// File: tb/tb_i_delay_obuf.sv
// Bench for i_delay_obuf: a per-cycle history of sampled inputs and a tap
// model predict data_o and dly_tap_val.
module tb_i_delay_obuf;

  localparam int unsigned DELAY     = 63;
  localparam int unsigned FIXED_DLY = 2;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       data_i;
  logic       dly_incdec;
  logic       dly_ld;
  logic       dly_adj;
  logic       data_o;
  logic [5:0] dly_tap_val;

  int vectors     = 0;
  int miscompares = 0;

  bit samp [0:65535];
  int cyc        = 0;
  int valid_from = 0;
  int tap_m      = DELAY;
  bit adjq_m     = 1'b1;
  bit exp_o      = 1'b0;

  i_delay_obuf #(.DELAY(DELAY), .FIXED_DLY(FIXED_DLY)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_i     (data_i),
    .dly_incdec (dly_incdec),
    .dly_ld     (dly_ld),
    .dly_adj    (dly_adj),
    .data_o     (data_o),
    .dly_tap_val(dly_tap_val)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock edge and update the reference model; returns 1 time unit later.
  task automatic tick();
    int src;
    @(posedge clk_i);
    if (!rst_ni) begin
      exp_o  = 1'b0;
      tap_m  = DELAY;
      adjq_m = 1'b1;
      cyc++;
      valid_from = cyc;
    end else begin
      src   = cyc - int'(FIXED_DLY + 63) + tap_m;
      exp_o = (src >= valid_from) ? !samp[src] : 1'b0;
      samp[cyc] = data_i;
      if (!dly_ld)
        tap_m = DELAY;
      else if (!dly_adj && adjq_m)
        tap_m = dly_incdec ? ((tap_m < 63) ? tap_m + 1 : 63) : ((tap_m > 0) ? tap_m - 1 : 0);
      adjq_m = dly_adj;
      cyc++;
    end
    #1;
  endtask

  task automatic pulse_adj(input bit dir);
    dly_incdec = dir;
    dly_adj = 1'b0;
    tick();
    tick();
    dly_adj = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; data_i = 1'b1; dly_ld = 1'b1; dly_adj = 1'b1; dly_incdec = 1'b0;
    tick();
    tick();
    vectors++;
    if (dly_tap_val !== 6'd63 || data_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state tap=%0d data_o=%b expected tap=63 data_o=0", dly_tap_val, data_o);
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (data_o !== 1'b0 || data_o !== exp_o || dly_tap_val !== 6'(tap_m)) begin
        miscompares++;
        $display("FAIL reset_hold i=%0d data_o=%b tap=%0d expected 0/%0d", i, data_o, dly_tap_val, tap_m);
      end
    end
  endtask

  task automatic test_edge();
    int lat = -1;
    data_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (data_o !== 1'b1) begin
      miscompares++;
      $display("FAIL edge_pre data_o=%b expected 1", data_o);
    end
    data_i = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (data_o === 1'b0) begin lat = i - 1; break; end
    end
    vectors++;
    if (lat != 2) begin
      miscompares++;
      $display("FAIL edge_latency got=%0d expected 2", lat);
    end
  endtask

  task automatic test_dec_ten();
    int lat = -1;
    for (int i = 0; i < 10; i++) pulse_adj(1'b0);
    vectors++;
    if (dly_tap_val !== 6'd53 || dly_tap_val !== 6'(tap_m)) begin
      miscompares++;
      $display("FAIL dec_ten tap=%0d expected 53", dly_tap_val);
    end
    data_i = 1'b0;
    for (int i = 0; i < 80; i++) tick();
    data_i = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (data_o === 1'b0) begin lat = i - 1; break; end
    end
    vectors++;
    if (lat != 12) begin
      miscompares++;
      $display("FAIL dec_ten_latency got=%0d expected 12", lat);
    end
  endtask

  task automatic test_hold_low();
    dly_ld = 1'b0; tick(); dly_ld = 1'b1; tick();
    pulse_adj(1'b0);
    vectors++;
    if (dly_tap_val !== 6'd62) begin
      miscompares++;
      $display("FAIL hold_setup tap=%0d expected 62", dly_tap_val);
    end
    dly_incdec = 1'b1;
    dly_adj = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    dly_adj = 1'b1;
    tick();
    vectors++;
    if (dly_tap_val !== 6'd63 || dly_tap_val !== 6'(tap_m)) begin
      miscompares++;
      $display("FAIL hold_low tap=%0d expected 63", dly_tap_val);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 66; i++) pulse_adj(1'b0);
    vectors++;
    if (dly_tap_val !== 6'd0) begin
      miscompares++;
      $display("FAIL sat_low tap=%0d expected 0", dly_tap_val);
    end
    pulse_adj(1'b0);
    vectors++;
    if (dly_tap_val !== 6'd0 || data_o !== exp_o) begin
      miscompares++;
      $display("FAIL sat_low_extra tap=%0d data_o=%b expected 0/%b", dly_tap_val, data_o, exp_o);
    end
    pulse_adj(1'b1);
    vectors++;
    if (dly_tap_val !== 6'd1) begin
      miscompares++;
      $display("FAIL sat_low_inc tap=%0d expected 1", dly_tap_val);
    end
    dly_ld = 1'b0; tick(); dly_ld = 1'b1; tick();
    pulse_adj(1'b1);
    vectors++;
    if (dly_tap_val !== 6'd63) begin
      miscompares++;
      $display("FAIL sat_high tap=%0d expected 63", dly_tap_val);
    end
  endtask

  task automatic test_ld_vs_adj();
    for (int i = 0; i < 23; i++) pulse_adj(1'b0);
    vectors++;
    if (dly_tap_val !== 6'd40) begin
      miscompares++;
      $display("FAIL ld_setup tap=%0d expected 40", dly_tap_val);
    end
    dly_incdec = 1'b0;
    dly_ld = 1'b0;
    dly_adj = 1'b0;
    tick();
    dly_ld = 1'b1;
    vectors++;
    if (dly_tap_val !== 6'd63 || dly_tap_val !== 6'(tap_m)) begin
      miscompares++;
      $display("FAIL ld_vs_adj tap=%0d expected 63", dly_tap_val);
    end
    tick();
    vectors++;
    if (dly_tap_val !== 6'd63) begin
      miscompares++;
      $display("FAIL ld_vs_adj_after tap=%0d expected 63", dly_tap_val);
    end
    dly_adj = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_adj(1'b0);
    for (int i = 0; i < 30; i++) begin
      data_i = 1'($urandom);
      tick();
    end
    data_i = 1'b0;
    #2 rst_ni = 1'b0;
    tap_m = DELAY; adjq_m = 1'b1; exp_o = 1'b0;
    #1;
    vectors++;
    if (data_o !== 1'b0 || dly_tap_val !== 6'd63) begin
      miscompares++;
      $display("FAIL reset_mid data_o=%b tap=%0d expected 0/63", data_o, dly_tap_val);
    end
    tick();
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (data_o !== exp_o || (i < 2 && data_o !== 1'b0)) begin
        miscompares++;
        $display("FAIL reset_mid_refill i=%0d data_o=%b expected %b", i, data_o, exp_o);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      data_i     = 1'($urandom);
      dly_incdec = ($urandom_range(0, 3) != 0);
      dly_adj    = ($urandom_range(0, 2) != 0);
      dly_ld     = ($urandom_range(0, 63) != 0);
      if (i % 400 == 200) dly_incdec = 1'b0;
      tick();
      vectors++;
      if (data_o !== exp_o || dly_tap_val !== 6'(tap_m)) begin
        miscompares++;
        $display("FAIL random cyc=%0d data_o=%b tap=%0d expected %b/%0d", cyc, data_o, dly_tap_val, exp_o, tap_m);
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0; data_i = 1'b0; dly_incdec = 1'b0; dly_ld = 1'b1; dly_adj = 1'b1;
    test_reset();
    test_edge();
    test_dec_ten();
    test_hold_low();
    test_saturation();
    test_ld_vs_adj();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
